// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : hazard_ctrl_pkg
// Brief   : State encodings, forwarding-select codes and helpers shared by the
//           hazard controller and its register-compare sub-module.
// Rev     : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int C_REG_AW = 5;
    localparam logic [C_REG_AW-1:0] C_REG_ZERO = 5'd0;

    typedef logic [1:0] hz_state_t;
    localparam hz_state_t C_ST_RUN       = 2'd0;
    localparam hz_state_t C_ST_STALL_RAW = 2'd1;
    localparam hz_state_t C_ST_WAIT_MEM  = 2'd2;
    localparam hz_state_t C_ST_FLUSH     = 2'd3;

    localparam logic [1:0] C_FWD_REG   = 2'b00;
    localparam logic [1:0] C_FWD_EXMEM = 2'b01;
    localparam logic [1:0] C_FWD_MEMWB = 2'b10;

    // The younger producer (EX/MEM) holds the newest value, so it wins.
    function automatic logic [1:0] fwd_select(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit) begin
            return C_FWD_EXMEM;
        end
        if (memwb_hit) begin
            return C_FWD_MEMWB;
        end
        return C_FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_raw_match.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl_raw_match
// Brief  : One source-vs-destination register compare; $0 never matches.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl_raw_match
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_rd_en,
    input  logic [4:0] i_dest,
    input  logic       i_we,
    output logic       o_match
);

    assign o_match = i_rd_en && i_we && (i_src != C_REG_ZERO) && (i_src == i_dest);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl
// Brief  : Stall/bubble/flush and EX forwarding control for a 5-stage MIPS
//          pipe. Macro FORWARDING_EN enables forwarding (load-use stalls only).
// Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_wr_addr,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_wr_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_wr_addr,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0]  C_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] C_TIMEOUT    = 16'(MEM_TIMEOUT);

    hz_state_t        state_q,     state_d;
    logic [2:0]       rem_q,       rem_d;
    logic             pend_q,      pend_d;
    logic [15:0]      wait_q,      wait_d;
    logic             mem_err_q,   mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0][4:0] w_id_src;
    logic [1:0][4:0] w_ex_src;
    logic [1:0]      w_id_use;
    logic [1:0]      w_id_ex_hit;
    logic [1:0]      w_id_mem_hit;
    logic [1:0]      w_ex_mem_hit;
    logic [1:0]      w_ex_wb_hit;

    logic        w_raw_hazard;
    logic        w_freeze;
    logic        w_flush_new;
    logic        w_flush_cont;
    logic        w_raw_stall;
    logic [15:0] w_wait_inc;

    assign w_id_src = {id_rt, id_rs};
    assign w_ex_src = {ex_rt, ex_rs};
    assign w_id_use = {id_use_rt, id_use_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            hazard_ctrl_raw_match u_id_ex (
                .i_src   (w_id_src[gi]),
                .i_rd_en (w_id_use[gi]),
                .i_dest  (ex_wr_addr),
                .i_we    (ex_reg_write),
                .o_match (w_id_ex_hit[gi])
            );
            hazard_ctrl_raw_match u_id_mem (
                .i_src   (w_id_src[gi]),
                .i_rd_en (w_id_use[gi]),
                .i_dest  (mem_wr_addr),
                .i_we    (mem_reg_write),
                .o_match (w_id_mem_hit[gi])
            );
            hazard_ctrl_raw_match u_ex_mem (
                .i_src   (w_ex_src[gi]),
                .i_rd_en (1'b1),
                .i_dest  (mem_wr_addr),
                .i_we    (mem_reg_write),
                .o_match (w_ex_mem_hit[gi])
            );
            hazard_ctrl_raw_match u_ex_wb (
                .i_src   (w_ex_src[gi]),
                .i_rd_en (1'b1),
                .i_dest  (wb_wr_addr),
                .i_we    (wb_reg_write),
                .o_match (w_ex_wb_hit[gi])
            );
        end
    endgenerate

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; everything else bypasses.
    assign w_raw_hazard = ex_mem_read && (|w_id_ex_hit);
    assign fwd_a        = fwd_select(w_ex_mem_hit[0], w_ex_wb_hit[0]);
    assign fwd_b        = fwd_select(w_ex_mem_hit[1], w_ex_wb_hit[1]);

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^w_id_mem_hit;
`else
    // Regfile writes in the first half-cycle, so a WB producer is already visible.
    assign w_raw_hazard = (|w_id_ex_hit) || (|w_id_mem_hit);
    assign fwd_a        = C_FWD_REG;
    assign fwd_b        = C_FWD_REG;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_ex_mem_hit, w_ex_wb_hit, ex_mem_read};
`endif

    assign w_freeze     = dm_req && !dm_ready;
    assign w_flush_new  = !w_freeze && (branch_taken || pend_q);
    // A flush interrupted by a memory wait resumes with its remaining count.
    assign w_flush_cont = !w_freeze && !w_flush_new &&
                          ((state_q == C_ST_FLUSH) ||
                           ((state_q == C_ST_WAIT_MEM) && (rem_q != 3'd0)));
    assign w_raw_stall  = !w_freeze && !w_flush_new && !w_flush_cont && w_raw_hazard;
    assign w_wait_inc   = (&wait_q) ? wait_q : wait_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= C_ST_RUN;
            rem_q       <= 3'd0;
            pend_q      <= 1'b0;
            wait_q      <= 16'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = C_ST_RUN;
        rem_d       = rem_q;
        pend_d      = 1'b0;
        wait_d      = 16'd0;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (w_freeze) begin
            state_d = C_ST_WAIT_MEM;
            pend_d  = pend_q || branch_taken;
            wait_d  = w_wait_inc;
            if (w_wait_inc >= C_TIMEOUT) begin
                mem_err_d = 1'b1;
            end
        end else if (w_flush_new) begin
            rem_d       = C_FLUSH_LOAD;
            state_d     = (C_FLUSH_LOAD != 3'd0) ? C_ST_FLUSH : C_ST_RUN;
            flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
        end else if (w_flush_cont) begin
            rem_d   = rem_q - 3'd1;
            state_d = (rem_q == 3'd1) ? C_ST_RUN : C_ST_FLUSH;
        end else if (w_raw_stall) begin
            state_d = C_ST_STALL_RAW;
        end

        if (w_freeze || w_raw_stall) begin
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        if (w_freeze) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (w_flush_new || w_flush_cont) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_raw_stall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed self-checking bench for hazard_ctrl (either FORWARDING_EN build).
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 3;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_wr_addr, mem_wr_addr, wb_wr_addr;
    logic             id_use_rs, id_use_rt, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic             branch_taken, dm_req, dm_ready;
    logic             pc_stall, if_id_stall, id_ex_stall, id_ex_bubble;
    logic             ex_mem_stall, mem_wb_bubble, if_id_flush, id_ex_flush;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       ctl;

    int checks;
    int failures;

    hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_wr_addr    (ex_wr_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_wr_addr   (mem_wr_addr),
        .mem_reg_write (mem_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .wb_reg_write  (wb_reg_write),
        .branch_taken  (branch_taken),
        .dm_req        (dm_req),
        .dm_ready      (dm_ready),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .id_ex_stall   (id_ex_stall),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_stall  (ex_mem_stall),
        .mem_wb_bubble (mem_wb_bubble),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc, if_id, id_ex_stall, id_ex_bubble, ex_mem, mem_wb_bubble, if_id_flush, id_ex_flush}
    assign ctl = {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble,
                  ex_mem_stall, mem_wb_bubble, if_id_flush, id_ex_flush};

    localparam logic [7:0] CTL_NONE   = 8'h00;
    localparam logic [7:0] CTL_RAW    = 8'hD0;
    localparam logic [7:0] CTL_FREEZE = 8'hEC;
    localparam logic [7:0] CTL_FLUSH  = 8'h03;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        id_rs = 5'd0;  id_rt = 5'd0;  id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_rs = 5'd0;  ex_rt = 5'd0;  ex_wr_addr = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_wr_addr = 5'd0; mem_reg_write = 1'b0;
        wb_wr_addr = 5'd0;  wb_reg_write = 1'b0;
        branch_taken = 1'b0; dm_req = 1'b0; dm_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1; settle();
        chk("reset_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        reset = 1'b0;

        // Writer to $0 with a reader of $0 everywhere: no hazard, no forward
        tick(); idle();
        ex_wr_addr = 5'd0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        mem_wr_addr = 5'd0; mem_reg_write = 1'b1; wb_wr_addr = 5'd0; wb_reg_write = 1'b1;
        id_use_rs = 1'b1; id_use_rt = 1'b1;
        settle();
        chk("zero_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("zero_fwd_a", 32'(fwd_a), 32'd0);
        chk("zero_fwd_b", 32'(fwd_b), 32'd0);

        // lw $8 in EX, add $9,$8,$8 in ID
        tick(); idle();
        ex_wr_addr = 5'd8; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs = 5'd8; id_rt = 5'd8; id_use_rs = 1'b1; id_use_rt = 1'b1;
        settle();
        chk("lu_stall", 32'(ctl), 32'(CTL_RAW));
        tick(); idle();
        mem_wr_addr = 5'd8; mem_reg_write = 1'b1;
        id_rs = 5'd8; id_rt = 5'd8; id_use_rs = 1'b1; id_use_rt = 1'b1;
        settle();
        chk("lu_second", 32'(ctl), 32'(FWD ? CTL_NONE : CTL_RAW));
        tick(); idle();
        ex_rs = 5'd8; ex_rt = 5'd8; ex_wr_addr = 5'd9; ex_reg_write = 1'b1;
        wb_wr_addr = 5'd8; wb_reg_write = 1'b1;
        id_rs = 5'd8; id_use_rs = 1'b1;
        settle();
        chk("lu_wb_no_stall", 32'(ctl), 32'(CTL_NONE));
        chk("lu_fwd_a", 32'(fwd_a), FWD ? 32'd2 : 32'd0);
        chk("lu_fwd_b", 32'(fwd_b), FWD ? 32'd2 : 32'd0);

        // add $8 in EX, sub $9,$8,$1 in ID
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd2);
        idle();
        ex_wr_addr = 5'd8; ex_reg_write = 1'b1;
        id_rs = 5'd8; id_rt = 5'd1; id_use_rs = 1'b1; id_use_rt = 1'b1;
        settle();
        chk("as_first", 32'(ctl), 32'(FWD ? CTL_NONE : CTL_RAW));
        tick(); idle();
        ex_rs = 5'd8; ex_rt = 5'd1; ex_wr_addr = 5'd9; ex_reg_write = 1'b1;
        mem_wr_addr = 5'd8; mem_reg_write = 1'b1; wb_wr_addr = 5'd8; wb_reg_write = 1'b1;
        id_rs = 5'd8; id_rt = 5'd1; id_use_rs = 1'b1; id_use_rt = 1'b1;
        settle();
        chk("as_second", 32'(ctl), 32'(FWD ? CTL_NONE : CTL_RAW));
        chk("as_fwd_a_exmem_wins", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
        chk("as_fwd_b", 32'(fwd_b), 32'd0);
        tick(); idle();
        ex_rt = 5'd3; mem_wr_addr = 5'd3; wb_wr_addr = 5'd3; wb_reg_write = 1'b1;
        settle();
        chk("fwd_b_memwb", 32'(fwd_b), FWD ? 32'd2 : 32'd0);
        chk("fwd_b_ctl", 32'(ctl), 32'(CTL_NONE));

        // Taken branch with a concurrent RAW hazard: flush wins, no stall
        tick();
        chk("as_stall_cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd4);
        idle();
        branch_taken = 1'b1;
        ex_wr_addr = 5'd8; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs = 5'd8; id_use_rs = 1'b1;
        settle();
        chk("br_flush1", 32'(ctl), 32'(CTL_FLUSH));
        tick(); idle(); settle();
        chk("br_flush2", 32'(ctl), 32'(CTL_FLUSH));
        tick(); settle();
        chk("br_done", 32'(ctl), 32'(CTL_NONE));
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

        // 5-cycle memory wait with a branch arriving in cycle 2
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) begin
                chk("wait_mem_err_pre", 32'(mem_err), 32'd0);
                chk("wait_flush_cnt_held", 32'(flush_cnt), 32'd1);
            end
            if (i == 5) begin
                chk("wait_mem_err_set", 32'(mem_err), 32'd1);
            end
            idle();
            dm_req = 1'b1;
            branch_taken = (i == 2);
            settle();
            chk("wait_freeze", 32'(ctl), 32'(CTL_FREEZE));
        end
        tick(); idle(); dm_req = 1'b1; dm_ready = 1'b1; settle();
        chk("wait_flush1", 32'(ctl), 32'(CTL_FLUSH));
        tick(); idle(); settle();
        chk("wait_flush2", 32'(ctl), 32'(CTL_FLUSH));
        tick(); settle();
        chk("wait_done", 32'(ctl), 32'(CTL_NONE));
        chk("wait_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("wait_mem_err_sticky", 32'(mem_err), 32'd1);
        chk("wait_stall_cnt", 32'(stall_cnt), FWD ? 32'd6 : 32'd7);

        // Reset in the middle of a flush aborts it and clears everything
        tick(); branch_taken = 1'b1; settle();
        chk("rst_pre_flush", 32'(ctl), 32'(CTL_FLUSH));
        tick(); idle(); reset = 1'b1; settle();
        chk("rst_abort_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        tick(); reset = 1'b0; settle();
        chk("rst_release_ctl", 32'(ctl), 32'(CTL_NONE));

        // 9 frozen cycles saturate the 3-bit stall counter at 7
        for (int i = 0; i < 9; i++) begin
            tick(); dm_req = 1'b1; settle();
        end
        tick(); dm_req = 1'b0; settle();
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd7);
        chk("sat_ctl", 32'(ctl), 32'(CTL_NONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
